// File: rtl/sat_add_rr_sched.sv
// rtl/sat_add_rr_sched.sv - round-robin shared signed saturating adder with registered result port
// Optional saturation statistics counter: SAT_ADD_RR_SCHED_STATS_EN
module sat_add_rr_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_rdy,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic [W-1:0]       res_sum,
    output logic [IDW-1:0]     res_id,
    output logic               res_sat,
    output logic [7:0]         sat_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           can_accept;
    logic           grant;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   sum_raw;
    logic [W-1:0]   sum_sat;
    logic           pos_ovf;
    logic           neg_ovf;
    logic           sat_next;
    logic [IDW-1:0] ptr_next;

    assign can_accept = (state == EMPTY) || res_rdy;
    assign res_vld    = (state == FULL);

    // Search starts at ptr and wraps; operand mux rides along so grant never depends on data.
    always_comb begin
        int idx;
        idx     = 0;
        req_rdy = '0;
        grant   = 1'b0;
        gnt_id  = '0;
        a_sel   = '0;
        b_sel   = '0;
        if (can_accept) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_REQ)
                    idx = idx - N_REQ;
                if (!grant && req_vld[idx]) begin
                    grant        = 1'b1;
                    gnt_id       = IDW'(idx);
                    req_rdy[idx] = 1'b1;
                    a_sel        = req_a[idx*W +: W];
                    b_sel        = req_b[idx*W +: W];
                end
            end
        end
    end

    assign sum_raw  = a_sel + b_sel;
    assign pos_ovf  = ~a_sel[W-1] & ~b_sel[W-1] &  sum_raw[W-1];
    assign neg_ovf  =  a_sel[W-1] &  b_sel[W-1] & ~sum_raw[W-1];
    assign sat_next = pos_ovf | neg_ovf;
    assign sum_sat  = pos_ovf ? {1'b0, {(W-1){1'b1}}} :
                      neg_ovf ? {1'b1, {(W-1){1'b0}}} : sum_raw;
    assign ptr_next = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ptr     <= '0;
            res_sum <= '0;
            res_id  <= '0;
            res_sat <= 1'b0;
        end else if (grant) begin
            state   <= FULL;
            ptr     <= ptr_next;
            res_sum <= sum_sat;
            res_id  <= gnt_id;
            res_sat <= sat_next;
        end else if (state == FULL && res_rdy) begin
            state   <= EMPTY;
        end
    end

`ifdef SAT_ADD_RR_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= 8'd0;
        else if (grant && sat_next && sat_cnt != 8'hFF)
            sat_cnt <= sat_cnt + 8'd1;
    end
`else
    assign sat_cnt = 8'd0;
`endif

endmodule
